// File: rtl/regfile_writer.sv
// Write-side front end for the 32x32 register file. ALU results take the
// single write port with strict priority; load results wait in a 2-entry
// FIFO. A pending scoreboard tracks outstanding destinations for the issue
// stage, and a combinational bypass exposes the write currently on the port.
module regfile_writer #(
    parameter int LQ_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        alu_valid,
    input  logic [4:0]  alu_rd,
    input  logic [31:0] alu_data,
    input  logic        ld_valid,
    output logic        ld_ready,
    input  logic [4:0]  ld_rd,
    input  logic [31:0] ld_data,
    input  logic        rsv_valid,
    input  logic [4:0]  rsv_rd,
    output logic [31:0] pending,
    output logic        write_enable,
    output logic [4:0]  write_addr,
    output logic [31:0] write_data,
    input  logic [4:0]  byp_addr_a,
    input  logic [4:0]  byp_addr_b,
    output logic        byp_hit_a,
    output logic        byp_hit_b,
    output logic [31:0] byp_data_a,
    output logic [31:0] byp_data_b
);

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } lq_entry_t;

    // Entry 0 is always the head; a pop shifts entry 1 down.
    lq_entry_t [LQ_DEPTH-1:0] lq_q, lq_d;
    logic [1:0]               cnt_q, cnt_d;

    logic        we_q, we_d;
    logic [4:0]  addr_q, addr_d;
    logic [31:0] data_q, data_d;
    logic [31:0] pend_q, pend_d;

    logic        push, pop;
    logic [1:0]  cnt_after_pop;
    lq_entry_t   new_entry;

    // ld_ready depends only on registered state, never on ALU traffic.
    assign ld_ready  = (cnt_q < 2'(LQ_DEPTH)) && !rst;
    assign push      = ld_valid && ld_ready;
    assign pop       = !alu_valid && (cnt_q != 2'd0);
    assign new_entry = '{rd: ld_rd, data: ld_data};

    // FIFO next state: shift on pop, then append the push behind what remains.
    always_comb begin
        lq_d          = lq_q;
        cnt_after_pop = cnt_q - {1'b0, pop};
        if (pop) begin
            lq_d[0] = lq_q[1];
        end
        if (push) begin
            lq_d[cnt_after_pop[0]] = new_entry;
        end
        cnt_d = cnt_after_pop + {1'b0, push};
    end

    // Port arbitration: ALU first, then FIFO head; rd 0 is consumed silently.
    always_comb begin
        we_d   = 1'b0;
        addr_d = addr_q;
        data_d = data_q;
        if (alu_valid) begin
            if (alu_rd != 5'd0) begin
                we_d   = 1'b1;
                addr_d = alu_rd;
                data_d = alu_data;
            end
        end else if (cnt_q != 2'd0) begin
            if (lq_q[0].rd != 5'd0) begin
                we_d   = 1'b1;
                addr_d = lq_q[0].rd;
                data_d = lq_q[0].data;
            end
        end
    end

    // Scoreboard: clear on the edge the write is registered, set wins ties.
    always_comb begin
        pend_d = pend_q;
        if (we_d) begin
            pend_d[addr_d] = 1'b0;
        end
        if (rsv_valid && (rsv_rd != 5'd0)) begin
            pend_d[rsv_rd] = 1'b1;
        end
        pend_d[0] = 1'b0;
    end

    // State registers; reset discards FIFO contents and kills any write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lq_q   <= '0;
            cnt_q  <= 2'd0;
            we_q   <= 1'b0;
            addr_q <= 5'd0;
            data_q <= 32'd0;
            pend_q <= 32'd0;
        end else begin
            lq_q   <= lq_d;
            cnt_q  <= cnt_d;
            we_q   <= we_d;
            addr_q <= addr_d;
            data_q <= data_d;
            pend_q <= pend_d;
        end
    end

    assign pending      = pend_q;
    assign write_enable = we_q;
    assign write_addr   = addr_q;
    assign write_data   = data_q;

    // Bypass the write currently on the port; r0 never bypasses.
    always_comb begin
        byp_hit_a  = we_q && (addr_q == byp_addr_a) && (byp_addr_a != 5'd0);
        byp_hit_b  = we_q && (addr_q == byp_addr_b) && (byp_addr_b != 5'd0);
        byp_data_a = byp_hit_a ? data_q : 32'd0;
        byp_data_b = byp_hit_b ? data_q : 32'd0;
    end

endmodule

// File: tb/tb_regfile_writer.sv
// Directed bench for regfile_writer: reset, ALU path, load path, priority,
// destination 0, scoreboard set/clear race with bypass, and mid-run reset.
module tb_regfile_writer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        alu_valid = 1'b0;
    logic [4:0]  alu_rd = '0;
    logic [31:0] alu_data = '0;
    logic        ld_valid = 1'b0;
    logic        ld_ready;
    logic [4:0]  ld_rd = '0;
    logic [31:0] ld_data = '0;
    logic        rsv_valid = 1'b0;
    logic [4:0]  rsv_rd = '0;
    logic [31:0] pending;
    logic        write_enable;
    logic [4:0]  write_addr;
    logic [31:0] write_data;
    logic [4:0]  byp_addr_a = '0;
    logic [4:0]  byp_addr_b = '0;
    logic        byp_hit_a, byp_hit_b;
    logic [31:0] byp_data_a, byp_data_b;

    int n_cmp = 0;
    int n_bad = 0;

    regfile_writer #(.LQ_DEPTH(2)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
        .rsv_valid(rsv_valid), .rsv_rd(rsv_rd), .pending(pending),
        .write_enable(write_enable), .write_addr(write_addr), .write_data(write_data),
        .byp_addr_a(byp_addr_a), .byp_addr_b(byp_addr_b),
        .byp_hit_a(byp_hit_a), .byp_hit_b(byp_hit_b),
        .byp_data_a(byp_data_a), .byp_data_b(byp_data_b)
    );

    always #5 clk = ~clk;

    // Advance one edge; inputs change and outputs are sampled 1 ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        alu_valid = 1'b0; ld_valid = 1'b0; rsv_valid = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        n_cmp++; if (write_enable !== 1'b0) begin n_bad++; $display("FAIL rst_we got %b want 0", write_enable); end
        n_cmp++; if (write_addr !== 5'd0) begin n_bad++; $display("FAIL rst_addr got %0d want 0", write_addr); end
        n_cmp++; if (write_data !== 32'd0) begin n_bad++; $display("FAIL rst_data got %h want 0", write_data); end
        n_cmp++; if (pending !== 32'd0) begin n_bad++; $display("FAIL rst_pending got %h want 0", pending); end
        n_cmp++; if (ld_ready !== 1'b0) begin n_bad++; $display("FAIL rst_ld_ready got %b want 0", ld_ready); end
        tick(); tick();
        rst = 1'b0;
        #1;
        n_cmp++; if (ld_ready !== 1'b1) begin n_bad++; $display("FAIL rel_ld_ready got %b want 1", ld_ready); end
    endtask

    task automatic test_alu();
        rsv_valid = 1'b1; rsv_rd = 5'd5;
        tick();
        rsv_valid = 1'b0;
        n_cmp++; if (pending !== 32'h0000_0020) begin n_bad++; $display("FAIL alu_rsv got %h want 00000020", pending); end
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
        tick();
        alu_valid = 1'b0;
        n_cmp++; if (write_enable !== 1'b1) begin n_bad++; $display("FAIL alu_we got %b want 1", write_enable); end
        n_cmp++; if (write_addr !== 5'd5) begin n_bad++; $display("FAIL alu_addr got %0d want 5", write_addr); end
        n_cmp++; if (write_data !== 32'hDEADBEEF) begin n_bad++; $display("FAIL alu_data got %h want deadbeef", write_data); end
        n_cmp++; if (pending !== 32'd0) begin n_bad++; $display("FAIL alu_clr got %h want 0", pending); end
        tick();
        n_cmp++; if (write_enable !== 1'b0) begin n_bad++; $display("FAIL alu_we_off got %b want 0", write_enable); end
        n_cmp++; if (write_addr !== 5'd5 || write_data !== 32'hDEADBEEF) begin
            n_bad++; $display("FAIL alu_hold got %0d/%h want 5/deadbeef", write_addr, write_data); end
    endtask

    task automatic test_load();
        ld_valid = 1'b1; ld_rd = 5'd7; ld_data = 32'h11;
        tick();
        ld_valid = 1'b0;
        n_cmp++; if (write_enable !== 1'b0) begin n_bad++; $display("FAIL ld_early got %b want 0", write_enable); end
        n_cmp++; if (ld_ready !== 1'b1) begin n_bad++; $display("FAIL ld_ready1 got %b want 1", ld_ready); end
        tick();
        n_cmp++; if (write_enable !== 1'b1 || write_addr !== 5'd7 || write_data !== 32'h11) begin
            n_bad++; $display("FAIL ld_write got %b/%0d/%h want 1/7/11", write_enable, write_addr, write_data); end
        tick();
        n_cmp++; if (write_enable !== 1'b0) begin n_bad++; $display("FAIL ld_done got %b want 0", write_enable); end
    endtask

    task automatic test_back_to_back();
        alu_valid = 1'b1; alu_rd = 5'd10; alu_data = 32'hA10;
        ld_valid = 1'b1; ld_rd = 5'd3; ld_data = 32'h333;
        tick();
        n_cmp++; if (write_addr !== 5'd10 || ld_ready !== 1'b1) begin
            n_bad++; $display("FAIL b2b_c1 got %0d/%b want 10/1", write_addr, ld_ready); end
        alu_rd = 5'd11; alu_data = 32'hA11; ld_rd = 5'd4; ld_data = 32'h444;
        tick();
        ld_valid = 1'b0;
        n_cmp++; if (write_addr !== 5'd11 || ld_ready !== 1'b0) begin
            n_bad++; $display("FAIL b2b_full got %0d/%b want 11/0", write_addr, ld_ready); end
        alu_rd = 5'd12; alu_data = 32'hA12;
        tick();
        n_cmp++; if (write_addr !== 5'd12 || write_data !== 32'hA12) begin
            n_bad++; $display("FAIL b2b_c3 got %0d/%h want 12/a12", write_addr, write_data); end
        alu_rd = 5'd13; alu_data = 32'hA13;
        tick();
        alu_valid = 1'b0;
        n_cmp++; if (write_addr !== 5'd13 || ld_ready !== 1'b0) begin
            n_bad++; $display("FAIL b2b_c4 got %0d/%b want 13/0", write_addr, ld_ready); end
        tick();
        n_cmp++; if (write_enable !== 1'b1 || write_addr !== 5'd3 || write_data !== 32'h333) begin
            n_bad++; $display("FAIL b2b_ld3 got %b/%0d/%h want 1/3/333", write_enable, write_addr, write_data); end
        n_cmp++; if (ld_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_ready got %b want 1", ld_ready); end
        tick();
        n_cmp++; if (write_enable !== 1'b1 || write_addr !== 5'd4 || write_data !== 32'h444) begin
            n_bad++; $display("FAIL b2b_ld4 got %b/%0d/%h want 1/4/444", write_enable, write_addr, write_data); end
        tick();
        n_cmp++; if (write_enable !== 1'b0) begin n_bad++; $display("FAIL b2b_empty got %b want 0", write_enable); end
    endtask

    task automatic test_rd0();
        alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hBAD0;
        rsv_valid = 1'b1; rsv_rd = 5'd0;
        tick();
        alu_valid = 1'b0; rsv_valid = 1'b0;
        n_cmp++; if (write_enable !== 1'b0 || pending !== 32'd0) begin
            n_bad++; $display("FAIL rd0_alu got %b/%h want 0/0", write_enable, pending); end
        ld_valid = 1'b1; ld_rd = 5'd0; ld_data = 32'hBAD1;
        tick();
        ld_valid = 1'b0;
        n_cmp++; if (write_enable !== 1'b0) begin n_bad++; $display("FAIL rd0_push got %b want 0", write_enable); end
        tick();
        n_cmp++; if (write_enable !== 1'b0 || ld_ready !== 1'b1) begin
            n_bad++; $display("FAIL rd0_pop got %b/%b want 0/1", write_enable, ld_ready); end
        tick();
        n_cmp++; if (write_enable !== 1'b0 || pending !== 32'd0) begin
            n_bad++; $display("FAIL rd0_after got %b/%h want 0/0", write_enable, pending); end
    endtask

    task automatic test_bypass();
        rsv_valid = 1'b1; rsv_rd = 5'd9;
        tick();
        rsv_valid = 1'b0;
        n_cmp++; if (pending !== 32'h0000_0200) begin n_bad++; $display("FAIL byp_rsv got %h want 00000200", pending); end
        alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'hCAFE0009;
        rsv_valid = 1'b1; rsv_rd = 5'd9;
        tick();
        alu_valid = 1'b0; rsv_valid = 1'b0;
        n_cmp++; if (pending !== 32'h0000_0200) begin n_bad++; $display("FAIL byp_setwins got %h want 00000200", pending); end
        byp_addr_a = 5'd9; byp_addr_b = 5'd8;
        #1;
        n_cmp++; if (byp_hit_a !== 1'b1 || byp_data_a !== 32'hCAFE0009) begin
            n_bad++; $display("FAIL byp_a got %b/%h want 1/cafe0009", byp_hit_a, byp_data_a); end
        n_cmp++; if (byp_hit_b !== 1'b0 || byp_data_b !== 32'd0) begin
            n_bad++; $display("FAIL byp_b got %b/%h want 0/0", byp_hit_b, byp_data_b); end
        byp_addr_b = 5'd9;
        #1;
        n_cmp++; if (byp_hit_b !== 1'b1 || byp_data_b !== 32'hCAFE0009) begin
            n_bad++; $display("FAIL byp_b9 got %b/%h want 1/cafe0009", byp_hit_b, byp_data_b); end
        tick();
        n_cmp++; if (byp_hit_a !== 1'b0 || byp_data_a !== 32'd0) begin
            n_bad++; $display("FAIL byp_idle got %b/%h want 0/0", byp_hit_a, byp_data_a); end
        // retire the second reservation of r9
        alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h99;
        tick();
        alu_valid = 1'b0;
        n_cmp++; if (pending !== 32'd0) begin n_bad++; $display("FAIL byp_clr got %h want 0", pending); end
        byp_addr_a = 5'd0; byp_addr_b = 5'd0;
    endtask

    task automatic test_reset_mid();
        alu_valid = 1'b1; alu_rd = 5'd20; alu_data = 32'h20;
        ld_valid = 1'b1; ld_rd = 5'd21; ld_data = 32'h21;
        rsv_valid = 1'b1; rsv_rd = 5'd25;
        tick();
        rsv_valid = 1'b0;
        alu_rd = 5'd22; alu_data = 32'h22; ld_rd = 5'd23; ld_data = 32'h23;
        tick();
        idle();
        n_cmp++; if (write_enable !== 1'b1 || ld_ready !== 1'b0 || pending !== 32'h0200_0000) begin
            n_bad++; $display("FAIL mid_pre got %b/%b/%h want 1/0/02000000", write_enable, ld_ready, pending); end
        rst = 1'b1;
        #1;
        n_cmp++; if (write_enable !== 1'b0 || write_addr !== 5'd0 || write_data !== 32'd0) begin
            n_bad++; $display("FAIL mid_rst got %b/%0d/%h want 0/0/0", write_enable, write_addr, write_data); end
        n_cmp++; if (pending !== 32'd0 || ld_ready !== 1'b0) begin
            n_bad++; $display("FAIL mid_rst_sb got %h/%b want 0/0", pending, ld_ready); end
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++; if (write_enable !== 1'b0) begin
                n_bad++; $display("FAIL mid_stale%0d got %b/%0d want 0", i, write_enable, write_addr); end
        end
        n_cmp++; if (ld_ready !== 1'b1) begin n_bad++; $display("FAIL mid_ready got %b want 1", ld_ready); end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_load();
        test_back_to_back();
        test_rd0();
        test_bypass();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Safety net so the run cannot hang.
    initial begin
        #100000;
        $display("FAIL timeout got running want finished");
        $fatal(1, "timeout");
    end

endmodule
